// File: rtl/led_pkg.sv
// led_pkg: shared LED width and arbiter state encoding
//   LED_W   : width of one LED pattern
//   state_t : arbiter FSM states
package led_pkg;
   localparam int LED_W = 16;
   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;
endpackage

// File: rtl/led_rr_pick.sv
// led_rr_pick: combinational round-robin picker
//   req   : request vector
//   last  : index of the previous owner
//   valid : some request is set
//   idx   : first set request searching upward from last+1, wrapping
module led_rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic               valid,
   output logic [IW-1:0]      idx
);
   // Walk from the lowest priority down so the highest-priority hit is written last.
   always_comb begin
      valid = 1'b0;
      idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (req[(int'(last) + i) % NUM_REQ]) begin
            valid = 1'b1;
            idx = IW'((int'(last) + i) % NUM_REQ);
         end
      end
   end
endmodule

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner of the user LEDs with a minimum dwell per grant
//   CLK, RST_N : clock, synchronous active-low reset
//   REQ_I      : per-requester request level
//   DATA_I     : packed 16-bit patterns, requester k at [16k+15:16k]
//   GNT_O      : one-hot grant, zero when idle
//   OWNER_O    : current or last owner index
//   BUSY_O     : a grant is active
//   LED_O      : selected pattern to the LED register
module led_arbiter
   import led_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DWELL_CYCLES = 50_000_000,
   localparam int IW = $clog2(NUM_REQ),
   localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [NUM_REQ-1:0]       REQ_I,
   input  logic [LED_W*NUM_REQ-1:0] DATA_I,
   output logic [NUM_REQ-1:0]       GNT_O,
   output logic [IW-1:0]            OWNER_O,
   output logic                     BUSY_O,
   output logic [LED_W-1:0]         LED_O
);
   state_t        state;
   logic [IW-1:0] last;
   logic [CW-1:0] cnt;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic          own_req;
   logic          release_now;
   led_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (REQ_I),
      .last  (last),
      .valid (pick_valid),
      .idx   (pick_idx)
   );
   assign own_req = REQ_I[OWNER_O];
   // Once the dwell has expired, hand over if the owner let go or anyone else is waiting.
   assign release_now = (cnt == '0) && (!own_req || |(REQ_I & ~GNT_O));
   assign BUSY_O = (state == OWN);
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= IDLE;
         GNT_O <= '0;
         OWNER_O <= '0;
         LED_O <= '0;
         last <= IW'(NUM_REQ - 1);
         cnt <= '0;
      end else if (state == IDLE) begin
         LED_O <= '0;
         GNT_O <= '0;
         if (pick_valid) begin
            state <= OWN;
            GNT_O <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            OWNER_O <= pick_idx;
            cnt <= CW'(DWELL_CYCLES - 1);
         end
      end else begin
         if (own_req) LED_O <= DATA_I[LED_W*int'(OWNER_O) +: LED_W];
         if (cnt != '0) cnt <= cnt - 1'b1;
         if (release_now) begin
            state <= IDLE;
            GNT_O <= '0;
            last <= OWNER_O;
         end
      end
   end
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: scoreboard bench for led_arbiter with NUM_REQ=4, DWELL_CYCLES=4
module tb_led_arbiter;
   typedef struct packed {
      logic [3:0]  gnt;
      logic [1:0]  owner;
      logic        busy;
      logic [15:0] led;
   } exp_t;
   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [3:0]  REQ_I = '0;
   logic [63:0] DATA_I = '0;
   logic [3:0]  GNT_O;
   logic [1:0]  OWNER_O;
   logic        BUSY_O;
   logic [15:0] LED_O;
   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   bit          m_own;
   logic [3:0]  m_gnt;
   int          m_owner, m_last, m_cnt;
   logic [15:0] m_led;
   led_arbiter #(.NUM_REQ(4), .DWELL_CYCLES(4)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .REQ_I   (REQ_I),
      .DATA_I  (DATA_I),
      .GNT_O   (GNT_O),
      .OWNER_O (OWNER_O),
      .BUSY_O  (BUSY_O),
      .LED_O   (LED_O)
   );
   always #5 CLK = ~CLK;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   // Reference behaviour for one rising edge, evaluated on the inputs held across it.
   task automatic model_step();
      bit found;
      bit oreq, rel;
      int w;
      if (!RST_N) begin
         m_own = 0; m_gnt = 0; m_owner = 0; m_led = 0; m_cnt = 0; m_last = 3;
      end else if (!m_own) begin
         m_led = 0;
         m_gnt = 0;
         found = 0;
         w = 0;
         for (int k = 1; k <= 4; k++) begin
            if (!found && REQ_I[(m_last + k) % 4]) begin
               found = 1;
               w = (m_last + k) % 4;
            end
         end
         if (found) begin
            m_own = 1; m_gnt = 4'b0001 << w; m_owner = w; m_cnt = 3;
         end
      end else begin
         oreq = REQ_I[m_owner];
         rel = (m_cnt == 0) && (!oreq || ((REQ_I & ~m_gnt) != 0));
         if (oreq) m_led = DATA_I[m_owner*16 +: 16];
         if (m_cnt > 0) m_cnt--;
         if (rel) begin
            m_own = 0; m_gnt = 0; m_last = m_owner;
         end
      end
      sb.push_back('{gnt: m_gnt, owner: 2'(m_owner), busy: m_own, led: m_led});
   endtask
   task automatic tick();
      exp_t e;
      model_step();
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("gnt", 32'(GNT_O), 32'(e.gnt));
         check("owner", 32'(OWNER_O), 32'(e.owner));
         check("busy", 32'(BUSY_O), 32'(e.busy));
         check("led", 32'(LED_O), 32'(e.led));
      end
   endtask
   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   initial begin
      // reset with all requests pending
      RST_N = 0; REQ_I = 4'b1111;
      DATA_I = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
      ticks(2);
      check("rst_gnt", 32'(GNT_O), 32'h0);
      check("rst_led", 32'(LED_O), 32'h0);
      check("rst_busy", 32'(BUSY_O), 32'h0);
      RST_N = 1;
      tick();
      check("first_gnt", 32'(GNT_O), 32'b0001);
      REQ_I = 0;
      ticks(8);
      // single requester holds indefinitely
      REQ_I = 4'b0010; DATA_I[31:16] = 16'hA5A5;
      tick();
      check("single_gnt", 32'(GNT_O), 32'b0010);
      tick();
      check("single_led", 32'(LED_O), 32'hA5A5);
      ticks(22);
      check("single_hold", 32'(GNT_O), 32'b0010);
      REQ_I = 0;
      ticks(8);
      // full contention
      DATA_I = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
      REQ_I = 4'b1111;
      ticks(26);
      REQ_I = 0;
      ticks(8);
      // early drop freezes the pattern until the dwell ends
      REQ_I = 4'b0100; DATA_I[47:32] = 16'h00FF;
      tick();
      check("drop_gnt", 32'(GNT_O), 32'b0100);
      tick();
      check("drop_led0", 32'(LED_O), 32'h00FF);
      REQ_I = 0; DATA_I[47:32] = 16'hFFFF;
      tick();
      check("drop_led1", 32'(LED_O), 32'h00FF);
      tick();
      check("drop_led2", 32'(LED_O), 32'h00FF);
      tick();
      check("drop_end_gnt", 32'(GNT_O), 32'h0);
      tick();
      check("drop_clear", 32'(LED_O), 32'h0);
      ticks(2);
      // late competitor under owner 1
      REQ_I = 4'b0010;
      ticks(2);
      check("late_owner", 32'(GNT_O), 32'b0010);
      REQ_I = 4'b1010;
      ticks(3);
      check("late_idle", 32'(GNT_O), 32'h0);
      tick();
      check("late_gnt", 32'(GNT_O), 32'b1000);
      REQ_I = 0;
      ticks(8);
      // reset in the middle of a grant to owner 2
      REQ_I = 4'b0100;
      ticks(2);
      check("mid_owner", 32'(GNT_O), 32'b0100);
      RST_N = 0; REQ_I = 4'b0101;
      tick();
      check("mid_rst_gnt", 32'(GNT_O), 32'h0);
      check("mid_rst_owner", 32'(OWNER_O), 32'h0);
      check("mid_rst_led", 32'(LED_O), 32'h0);
      RST_N = 1;
      tick();
      check("mid_resume", 32'(GNT_O), 32'b0001);
      // random traffic against the model
      for (int i = 0; i < 120; i++) begin
         REQ_I = 4'($urandom_range(0, 15));
         DATA_I = {$urandom, $urandom};
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
